// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: NPORTS-input round-robin arbiter with a per-port packet-length timeout.
//
// Grants one requester at a time with a one-hot registered grant. The grant is held while the
// owner keeps requesting and its timer has not expired. On release or expiry, the grant rotates to
// the next requester after the previous owner.
//
// Optional feature: define ARB_TAIL_RELEASE_EN to release the grant when the owner presents TAIL_ID.
//
// Ports:
//   i_clk          clock, all state on posedge
//   i_rst_n        asynchronous active-low reset
//   i_req          per-port request
//   i_flit_id      per-port flit type, port i = [i*FID_W +: FID_W]
//   i_length       per-port packet length, port i = [i*LEN_W +: LEN_W]
//   o_grant        one-hot registered grant, all zero = idle
//   o_grant_valid  |o_grant
//   o_timeout      1-cycle pulse: port lost its grant by expiry while still requesting
module rr_timeout_arbiter #(
  parameter int unsigned      NPORTS    = 5,
  parameter int unsigned      LEN_W     = 12,
  parameter int unsigned      FID_W     = 3,
  parameter logic [FID_W-1:0] HEADER_ID = 3'b001,
  parameter logic [FID_W-1:0] TAIL_ID   = 3'b100
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NPORTS-1:0]       i_req,
  input  logic [NPORTS*FID_W-1:0] i_flit_id,
  input  logic [NPORTS*LEN_W-1:0] i_length,
  output logic [NPORTS-1:0]       o_grant,
  output logic                    o_grant_valid,
  output logic [NPORTS-1:0]       o_timeout
);

  localparam int unsigned PTR_W = $clog2(NPORTS);

`ifdef ARB_TAIL_RELEASE_EN
  localparam bit TailRelease = 1'b1;
`else
  localparam bit TailRelease = 1'b0;
`endif

  logic [NPORTS-1:0] r_grant, r_timeout;
  logic [PTR_W-1:0]  r_ptr;
  logic [LEN_W-1:0]  r_limit [NPORTS];
  logic [LEN_W-1:0]  r_count [NPORTS];

  logic [FID_W-1:0]  w_fid [NPORTS];
  logic [LEN_W-1:0]  w_len [NPORTS];
  logic [NPORTS-1:0] w_expired;
  logic [PTR_W-1:0]  w_owner, w_idx, w_pick, w_ptr_d;
  logic [NPORTS-1:0] w_grant_d, w_timeout_d;
  logic              w_legal, w_owner_req, w_expired_o, w_tail, w_hit, w_hold;

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_port
      assign w_fid[g]     = i_flit_id[g*FID_W +: FID_W];
      assign w_len[g]     = i_length[g*LEN_W +: LEN_W];
      assign w_expired[g] = (r_count[g] == r_limit[g]);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_limit[g] <= '0;
          r_count[g] <= '0;
        end else begin
          // Limit follows every header, granted or not; expiry this cycle still sees the old one.
          if (w_fid[g] == HEADER_ID) r_limit[g] <= w_len[g];
          if (w_hold && (w_owner == PTR_W'(g))) begin
            r_count[g] <= (r_count[g] == '1) ? r_count[g] : r_count[g] + 1'b1;
          end else begin
            r_count[g] <= '0;
          end
        end
      end
    end
  endgenerate

  // Exactly one bit set; an X or multi-hot grant evaluates false here and recovers to idle.
  assign w_legal = (r_grant != '0) && ((r_grant & (r_grant - 1'b1)) == '0);

  always_comb begin
    w_owner = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (r_grant[PTR_W'(i)]) w_owner = PTR_W'(i);
    end
  end

  assign w_owner_req = i_req[w_owner];
  assign w_expired_o = w_expired[w_owner];
  assign w_tail      = TailRelease && w_legal && w_owner_req && (w_fid[w_owner] == TAIL_ID);

  // Search ptr+1 .. ptr+NPORTS so the previous owner is considered last.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_ptr;
    w_idx  = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      w_idx = PTR_W'((32'(r_ptr) + k) % NPORTS);
      if (!w_hit && i_req[w_idx]) begin
        w_hit  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_d   = '0;
    w_ptr_d     = r_ptr;
    w_timeout_d = '0;
    w_hold      = 1'b0;
    if (w_legal) begin
      if (w_owner_req && !w_expired_o && !w_tail) begin
        w_hold    = 1'b1;
        w_grant_d = r_grant;
      end else if (w_owner_req && w_expired_o) begin
        w_timeout_d[w_owner] = 1'b1;
      end
    end
    if ((w_legal || (r_grant == '0)) && !w_hold && w_hit) begin
      w_grant_d[w_pick] = 1'b1;
      w_ptr_d           = w_pick;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant   <= '0;
      r_timeout <= '0;
      r_ptr     <= PTR_W'(NPORTS - 1);
    end else begin
      r_grant   <= w_grant_d;
      r_timeout <= w_timeout_d;
      r_ptr     <= w_ptr_d;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = |r_grant;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
module tb_rr_timeout_arbiter;

  localparam int NP = 5;
  localparam int LW = 12;
  localparam int FW = 3;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;
  localparam logic [2:0] BODY = 3'b010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP*FW-1:0] fid;
  logic [NP*LW-1:0] len;
  logic [NP-1:0]    grant, tout;
  logic             gv;

  int n_vec = 0;
  int n_err = 0;

  rr_timeout_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_flit_id    (fid),
    .i_length     (len),
    .o_grant      (grant),
    .o_grant_valid(gv),
    .o_timeout    (tout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic [2:0] f, input logic [11:0] l);
    req[p]          = r;
    fid[p*FW +: FW] = f;
    len[p*LW +: LW] = l;
  endtask

  // Called 1 time unit after an edge: pulses reset between edges and clears inputs.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    fid   = '0;
    len   = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fid   = '0;
    len   = '0;
    for (int c = 0; c < 3; c++) begin
      req = NP'($urandom_range(1, 31));
      step();
      n_vec++;
      if (grant !== 5'b0 || gv !== 1'b0 || tout !== 5'b0) begin
        n_err++;
        $display("FAIL reset_hold c%0d: grant=%b gv=%b tout=%b want 0/0/0", c, grant, gv, tout);
      end
    end
    req   = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++;
      if (grant !== 5'b0 || gv !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: grant=%b gv=%b want 00000/0", c, grant, gv);
      end
    end
    req = 5'b00100;
    step();
    n_vec++;
    if (grant !== 5'b00100 || gv !== 1'b1) begin
      n_err++;
      $display("FAIL first_grant: grant=%b gv=%b want 00100/1", grant, gv);
    end
  endtask

  task automatic test_hold_expiry();
    do_reset();
    set_port(2, 1'b1, HDR, 12'd3);
    step();
    set_port(2, 1'b1, BODY, 12'd0);
    // counts 0..3: four granted cycles, no pulse
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (grant !== 5'b00100 || tout !== 5'b0) begin
        n_err++;
        $display("FAIL hold c%0d: grant=%b tout=%b want 00100/00000", c, grant, tout);
      end
      if (c < 3) step();
    end
    step();
    n_vec++;
    if (grant !== 5'b00100 || tout !== 5'b00100) begin
      n_err++;
      $display("FAIL expiry_regrant: grant=%b tout=%b want 00100/00100", grant, tout);
    end
    step();
    n_vec++;
    if (grant !== 5'b00100 || tout !== 5'b00000) begin
      n_err++;
      $display("FAIL expiry_after: grant=%b tout=%b want 00100/00000", grant, tout);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] eg, et;
    do_reset();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      eg = NP'(1) << (k % NP);
      et = (k == 0) ? 5'b0 : NP'(1) << ((k - 1) % NP);
      n_vec++;
      if (grant !== eg || tout !== et) begin
        n_err++;
        $display("FAIL rr c%0d: grant=%b tout=%b want %b/%b", k, grant, tout, eg, et);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    set_port(1, 1'b1, HDR, 12'd10);
    step();
    set_port(1, 1'b1, BODY, 12'd0);
    set_port(3, 1'b1, BODY, 12'd0);
    step();
    step();
    n_vec++;
    if (grant !== 5'b00010) begin
      n_err++;
      $display("FAIL release_hold: grant=%b want 00010", grant);
    end
    req[1] = 1'b0;
    step();
    n_vec++;
    if (grant !== 5'b01000 || tout !== 5'b0) begin
      n_err++;
      $display("FAIL release: grant=%b tout=%b want 01000/00000", grant, tout);
    end
  endtask

  task automatic test_tail();
    logic [NP-1:0] eg;
    do_reset();
    set_port(0, 1'b1, HDR, 12'd20);
    step();
    set_port(0, 1'b1, BODY, 12'd0);
    set_port(4, 1'b1, BODY, 12'd0);
    for (int c = 0; c < 5; c++) step();
    n_vec++;
    if (grant !== 5'b00001) begin
      n_err++;
      $display("FAIL tail_pre: grant=%b want 00001", grant);
    end
    set_port(0, 1'b1, TAIL, 12'd0);
`ifdef ARB_TAIL_RELEASE_EN
    eg = 5'b10000;
`else
    eg = 5'b00001;
`endif
    step();
    n_vec++;
    if (grant !== eg || tout !== 5'b0) begin
      n_err++;
      $display("FAIL tail: grant=%b tout=%b want %b/00000", grant, tout, eg);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_port(3, 1'b1, HDR, 12'd20);
    step();
    n_vec++;
    if (grant !== 5'b01000) begin
      n_err++;
      $display("FAIL async_pre: grant=%b want 01000", grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (grant !== 5'b0 || gv !== 1'b0 || tout !== 5'b0) begin
      n_err++;
      $display("FAIL async_clear: grant=%b gv=%b tout=%b want 0/0/0", grant, gv, tout);
    end
    #2;
    rst_n = 1'b1;
    req   = 5'b11111;
    fid   = '0;
    step();
    n_vec++;
    if (grant !== 5'b00001) begin
      n_err++;
      $display("FAIL async_restart: grant=%b want 00001", grant);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    fid   = '0;
    len   = '0;
    test_reset();
    test_hold_expiry();
    test_round_robin();
    test_release();
    test_tail();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
